trd_sched: RTL and testbench

Thread scheduler for the 8-thread register file set. Tracks the lifecycle of each hardware thread, picks the thread decoded each cycle by rotating priority, and sequences thread spawn by allocating a free thread and driving the register file set's init/init_trd pair. Sits between fetch/decode control and the register file set; trd_dec feeds both.

---
 rtl/trd_sched.sv | 188 ++++++++++++++++++
 tb/tb_trd_sched.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/trd_sched.sv
// Thread scheduler for the 8-thread register file set: per-thread lifecycle,
// rotating-priority decode selection and spawn/init sequencing.
module trd_sched #(
  parameter int NUM_TRD = 8,
  parameter int STALL_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               issue_en,
  input  logic               spawn_req,
  input  logic               kill_req,
  input  logic [2:0]         kill_trd,
  input  logic               stall_req,
  input  logic [2:0]         stall_trd,
  input  logic [STALL_W-1:0] stall_cyc,
  input  logic               wake_req,
  input  logic [2:0]         wake_trd,
  output logic [2:0]         trd_dec,
  output logic               trd_vld,
  output logic               init,
  output logic [2:0]         init_trd,
  output logic               spawn_ack,
  output logic               spawn_fail,
  output logic [2:0]         spawn_trd,
  output logic [NUM_TRD-1:0] active_mask
);

  typedef enum logic [2:0] {
    ST_FREE  = 3'd0,
    ST_INIT  = 3'd1,
    ST_READY = 3'd2,
    ST_WAIT  = 3'd3,
    ST_BLOCK = 3'd4
  } trd_st_t;

  localparam logic [STALL_W-1:0] CNT_ZERO = {STALL_W{1'b0}};
  localparam logic [STALL_W-1:0] CNT_ONE  = {{(STALL_W-1){1'b0}}, 1'b1};

  trd_st_t            st_r  [NUM_TRD];
  trd_st_t            st_s  [NUM_TRD];
  logic [STALL_W-1:0] cnt_r [NUM_TRD];
  logic [STALL_W-1:0] cnt_s [NUM_TRD];
  logic [NUM_TRD-1:0] free_s;
  logic [NUM_TRD-1:0] ready_s;
  logic [NUM_TRD-1:0] mask_s;
  logic [3:0]         alloc_s;
  logic [3:0]         sel_s;
  logic [2:0]         ptr_r;

  // Lowest set bit of mask as {found, index}.
  function automatic logic [3:0] pick_low(input logic [NUM_TRD-1:0] mask);
    logic [3:0] res;
    res = 4'b0000;
    for (int i = NUM_TRD - 1; i >= 0; i--) begin
      res = mask[i] ? {1'b1, 3'(i)} : res;
    end
    return res;
  endfunction

  // First set bit strictly after last, wrapping; last itself is tried last.
  function automatic logic [3:0] pick_rot(input logic [NUM_TRD-1:0] mask,
                                          input logic [2:0]         last);
    logic [3:0] res;
    logic [2:0] idx;
    res = 4'b0000;
    for (int k = NUM_TRD; k >= 1; k--) begin
      idx = last + 3'(k);
      res = mask[idx] ? {1'b1, idx} : res;
    end
    return res;
  endfunction

  // Free/ready views of the current thread states.
  always_comb begin
    free_s  = {NUM_TRD{1'b0}};
    ready_s = {NUM_TRD{1'b0}};
    for (int i = 0; i < NUM_TRD; i++) begin
      free_s[i]  = (st_r[i] == ST_FREE);
      ready_s[i] = (st_r[i] == ST_READY);
    end
  end

  assign alloc_s = pick_low(free_s);
  assign sel_s   = pick_rot(ready_s, ptr_r);

  // Per-thread next state; same-thread priority kill > stall > wake.
  always_comb begin
    mask_s = {NUM_TRD{1'b0}};
    for (int i = 0; i < NUM_TRD; i++) begin
      st_s[i]  = st_r[i];
      cnt_s[i] = cnt_r[i];
      if (kill_req && (kill_trd == 3'(i)) && (st_r[i] != ST_FREE)) begin
        st_s[i]  = ST_FREE;
        cnt_s[i] = CNT_ZERO;
      end else if (stall_req && (stall_trd == 3'(i)) && (st_r[i] == ST_READY)) begin
        if (stall_cyc == CNT_ZERO) begin
          st_s[i]  = ST_BLOCK;
          cnt_s[i] = CNT_ZERO;
        end else begin
          st_s[i]  = ST_WAIT;
          cnt_s[i] = stall_cyc;
        end
      end else if (wake_req && (wake_trd == 3'(i)) &&
                   ((st_r[i] == ST_WAIT) || (st_r[i] == ST_BLOCK))) begin
        st_s[i]  = ST_READY;
        cnt_s[i] = CNT_ZERO;
      end else begin
        case (st_r[i])
          ST_FREE: begin
            if (spawn_req && alloc_s[3] && (alloc_s[2:0] == 3'(i))) begin
              st_s[i]  = ST_INIT;
              cnt_s[i] = CNT_ONE;
            end else begin
              st_s[i] = ST_FREE;
            end
          end
          // Two INIT cycles: the register set writes one stage after init.
          ST_INIT: begin
            if (cnt_r[i] != CNT_ZERO) begin
              cnt_s[i] = cnt_r[i] - CNT_ONE;
            end else begin
              st_s[i] = ST_READY;
            end
          end
          ST_WAIT: begin
            if (cnt_r[i] <= CNT_ONE) begin
              st_s[i]  = ST_READY;
              cnt_s[i] = CNT_ZERO;
            end else begin
              cnt_s[i] = cnt_r[i] - CNT_ONE;
            end
          end
          default: begin
            st_s[i] = st_r[i];
          end
        endcase
      end
      mask_s[i] = (st_s[i] != ST_FREE);
    end
  end

  // Thread state and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_TRD; i++) begin
        st_r[i]  <= (i == 0) ? ST_READY : ST_FREE;
        cnt_r[i] <= CNT_ZERO;
      end
    end else begin
      for (int i = 0; i < NUM_TRD; i++) begin
        st_r[i]  <= st_s[i];
        cnt_r[i] <= cnt_s[i];
      end
    end
  end

  // Registered issue, spawn response and activity outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trd_dec     <= 3'd0;
      trd_vld     <= 1'b0;
      ptr_r       <= 3'd7;
      init        <= 1'b0;
      init_trd    <= 3'd0;
      spawn_ack   <= 1'b0;
      spawn_fail  <= 1'b0;
      spawn_trd   <= 3'd0;
      active_mask <= {{(NUM_TRD-1){1'b0}}, 1'b1};
    end else begin
      spawn_ack   <= spawn_req;
      spawn_fail  <= spawn_req && !alloc_s[3];
      init        <= spawn_req && alloc_s[3];
      active_mask <= mask_s;
      if (spawn_req && alloc_s[3]) begin
        spawn_trd <= alloc_s[2:0];
        init_trd  <= alloc_s[2:0];
      end
      if (issue_en && sel_s[3]) begin
        trd_dec <= sel_s[2:0];
        trd_vld <= 1'b1;
        ptr_r   <= sel_s[2:0];
      end else begin
        trd_vld <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_trd_sched.sv
// Scoreboard bench for trd_sched: a behavioural thread model predicts each
// cycle's outputs, which are queued at drive time and compared after the edge.
module tb_trd_sched;

  localparam int M_FREE  = 0;
  localparam int M_INIT  = 1;
  localparam int M_READY = 2;
  localparam int M_WAIT  = 3;
  localparam int M_BLOCK = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       issue_en = 1'b1;
  logic       spawn_req = 1'b0;
  logic       kill_req = 1'b0;
  logic [2:0] kill_trd = 3'd0;
  logic       stall_req = 1'b0;
  logic [2:0] stall_trd = 3'd0;
  logic [3:0] stall_cyc = 4'd0;
  logic       wake_req = 1'b0;
  logic [2:0] wake_trd = 3'd0;
  logic [2:0] trd_dec;
  logic       trd_vld;
  logic       init;
  logic [2:0] init_trd;
  logic       spawn_ack;
  logic       spawn_fail;
  logic [2:0] spawn_trd;
  logic [7:0] active_mask;

  typedef struct {
    logic [2:0] trd_dec;
    logic       trd_vld;
    logic       init;
    logic [2:0] init_trd;
    logic       spawn_ack;
    logic       spawn_fail;
    logic [2:0] spawn_trd;
    logic [7:0] active_mask;
  } exp_t;

  exp_t sb_q[$];
  exp_t last_e;
  int   m_st[8];
  int   m_cnt[8];
  int   m_ptr;
  int   n_chk = 0;
  int   n_err = 0;

  trd_sched #(.NUM_TRD(8), .STALL_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .issue_en(issue_en), .spawn_req(spawn_req),
    .kill_req(kill_req), .kill_trd(kill_trd), .stall_req(stall_req),
    .stall_trd(stall_trd), .stall_cyc(stall_cyc), .wake_req(wake_req),
    .wake_trd(wake_trd), .trd_dec(trd_dec), .trd_vld(trd_vld), .init(init),
    .init_trd(init_trd), .spawn_ack(spawn_ack), .spawn_fail(spawn_fail),
    .spawn_trd(spawn_trd), .active_mask(active_mask)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      m_st[i]  = (i == 0) ? M_READY : M_FREE;
      m_cnt[i] = 0;
    end
    m_ptr = 7;
    last_e = '{trd_dec: 3'd0, trd_vld: 1'b0, init: 1'b0, init_trd: 3'd0,
               spawn_ack: 1'b0, spawn_fail: 1'b0, spawn_trd: 3'd0, active_mask: 8'h01};
  endtask

  // Asynchronous reset pulse placed mid-cycle, outputs checked while held.
  task automatic reset_pulse();
    #4;
    rst_n = 1'b0;
    spawn_req = 1'b0; kill_req = 1'b0; stall_req = 1'b0; wake_req = 1'b0;
    #1;
    check("rst_trd_dec", trd_dec, 32'd0);
    check("rst_trd_vld", trd_vld, 32'd0);
    check("rst_init", init, 32'd0);
    check("rst_init_trd", init_trd, 32'd0);
    check("rst_spawn_ack", spawn_ack, 32'd0);
    check("rst_spawn_fail", spawn_fail, 32'd0);
    check("rst_spawn_trd", spawn_trd, 32'd0);
    check("rst_active_mask", active_mask, 32'h01);
    model_reset();
    #2;
    rst_n = 1'b1;
  endtask

  task automatic step();
    exp_t e;
    exp_t g;
    int   alloc;
    int   sel;
    int   j;
    int   nst[8];
    int   ncnt[8];
    e = last_e;
    alloc = -1;
    for (int i = 0; i < 8; i++) if (m_st[i] == M_FREE && alloc < 0) alloc = i;
    e.spawn_ack  = spawn_req;
    e.spawn_fail = spawn_req && (alloc < 0);
    e.init       = spawn_req && (alloc >= 0);
    if (e.init) begin
      e.init_trd  = 3'(alloc);
      e.spawn_trd = 3'(alloc);
    end
    sel = -1;
    for (int k = 1; k <= 8; k++) begin
      j = (m_ptr + k) % 8;
      if (m_st[j] == M_READY && sel < 0) sel = j;
    end
    if (issue_en && sel >= 0) begin
      e.trd_dec = 3'(sel);
      e.trd_vld = 1'b1;
      m_ptr = sel;
    end else begin
      e.trd_vld = 1'b0;
    end
    for (int i = 0; i < 8; i++) begin
      nst[i] = m_st[i];
      ncnt[i] = m_cnt[i];
      if (m_st[i] == M_INIT) begin
        ncnt[i] = m_cnt[i] - 1;
        if (ncnt[i] == 0) nst[i] = M_READY;
      end else if (m_st[i] == M_WAIT) begin
        if (m_cnt[i] == 1) begin nst[i] = M_READY; ncnt[i] = 0; end
        else ncnt[i] = m_cnt[i] - 1;
      end
    end
    if (wake_req && (m_st[wake_trd] == M_WAIT || m_st[wake_trd] == M_BLOCK)) begin
      nst[wake_trd] = M_READY; ncnt[wake_trd] = 0;
    end
    if (stall_req && m_st[stall_trd] == M_READY) begin
      nst[stall_trd] = (stall_cyc == 4'd0) ? M_BLOCK : M_WAIT;
      ncnt[stall_trd] = int'(stall_cyc);
    end
    if (kill_req && m_st[kill_trd] != M_FREE) begin
      nst[kill_trd] = M_FREE; ncnt[kill_trd] = 0;
    end
    if (spawn_req && alloc >= 0) begin
      nst[alloc] = M_INIT; ncnt[alloc] = 2;
    end
    for (int i = 0; i < 8; i++) begin
      m_st[i] = nst[i];
      m_cnt[i] = ncnt[i];
      e.active_mask[i] = (nst[i] != M_FREE);
    end
    last_e = e;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    g = sb_q.pop_front();
    check("trd_dec", trd_dec, g.trd_dec);
    check("trd_vld", trd_vld, g.trd_vld);
    check("init", init, g.init);
    check("init_trd", init_trd, g.init_trd);
    check("spawn_ack", spawn_ack, g.spawn_ack);
    check("spawn_fail", spawn_fail, g.spawn_fail);
    check("spawn_trd", spawn_trd, g.spawn_trd);
    check("active_mask", active_mask, g.active_mask);
  endtask

  task automatic go(input logic sp, input logic kl, input logic [2:0] kt,
                    input logic st, input logic [2:0] stt, input logic [3:0] sc,
                    input logic wk, input logic [2:0] wt);
    spawn_req = sp; kill_req = kl; kill_trd = kt;
    stall_req = st; stall_trd = stt; stall_cyc = sc;
    wake_req = wk; wake_trd = wt;
    step();
    spawn_req = 1'b0; kill_req = 1'b0; stall_req = 1'b0; wake_req = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) go(1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 4'd0, 1'b0, 3'd0);
  endtask

  initial begin
    @(posedge clk);
    #1;
    reset_pulse();
    idle(3);
    for (int i = 0; i < 3; i++) go(1'b1, 1'b0, 3'd0, 1'b0, 3'd0, 4'd0, 1'b0, 3'd0);
    idle(8);
    go(1'b0, 1'b1, 3'd2, 1'b0, 3'd0, 4'd0, 1'b0, 3'd0);
    go(1'b0, 1'b1, 3'd3, 1'b0, 3'd0, 4'd0, 1'b0, 3'd0);
    idle(2);
    go(1'b0, 1'b0, 3'd0, 1'b1, 3'd1, 4'd3, 1'b0, 3'd0);
    idle(6);
    go(1'b0, 1'b0, 3'd0, 1'b1, 3'd1, 4'd0, 1'b0, 3'd0);
    idle(3);
    go(1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 4'd0, 1'b1, 3'd1);
    idle(3);
    for (int i = 0; i < 6; i++) go(1'b1, 1'b0, 3'd0, 1'b0, 3'd0, 4'd0, 1'b0, 3'd0);
    idle(3);
    check("mask_full", active_mask, 32'hFF);
    go(1'b1, 1'b0, 3'd0, 1'b0, 3'd0, 4'd0, 1'b0, 3'd0);
    check("full_spawn_fail", spawn_fail, 32'd1);
    go(1'b0, 1'b1, 3'd5, 1'b0, 3'd0, 4'd0, 1'b0, 3'd0);
    go(1'b1, 1'b1, 3'd2, 1'b1, 3'd2, 4'd2, 1'b1, 3'd2);
    check("conflict_alloc", spawn_trd, 32'd5);
    idle(3);
    go(1'b1, 1'b0, 3'd0, 1'b0, 3'd0, 4'd0, 1'b0, 3'd0);
    idle(3);
    issue_en = 1'b0;
    idle(3);
    issue_en = 1'b1;
    for (int n = 0; n < 250; n++) begin
      issue_en = ($urandom_range(0, 9) != 0);
      go(($urandom_range(0, 3) == 0),
         ($urandom_range(0, 7) == 0), 3'($urandom_range(0, 7)),
         ($urandom_range(0, 3) == 0), 3'($urandom_range(0, 7)), 4'($urandom_range(0, 5)),
         ($urandom_range(0, 2) == 0), 3'($urandom_range(0, 7)));
    end
    issue_en = 1'b1;
    go(1'b1, 1'b0, 3'd0, 1'b1, 3'd0, 4'd7, 1'b0, 3'd0);
    reset_pulse();
    idle(3);
    for (int i = 0; i < 8; i++) go(1'b0, 1'b1, 3'(i), 1'b0, 3'd0, 4'd0, 1'b0, 3'd0);
    idle(3);
    check("idle_vld", trd_vld, 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
